// File: rtl/cache_controller.sv
// cache_controller
// Direct-mapped, write-back, write-allocate data cache: 4 lines of 4 words each.
// It sits between a CPU word port and a main memory that transfers 128-bit blocks.
// A miss runs WRITEBACK (only when the victim is dirty), then ALLOCATE, then
// returns to COMPARE, which now hits and completes the access.
//
// Ports
//   clk, reset          rising-edge clock; synchronous active-high reset
//   cpu_req/we/addr/wdata  request inputs, sampled only while cpu_ready=1
//   cpu_ready           idle and able to accept a request
//   cpu_done            one-cycle completion pulse
//   cpu_rdata           load data, valid only while cpu_done=1 (otherwise 0)
//   mem_read_write      1 = block write to memory, 0 = block read
//   mem_address         block byte address, bits [3:0] always 0
//   mem_write_data      victim block driven during WRITEBACK
//   mem_read_data       block returned by memory (combinational)
//   hit_count/miss_count  saturating first-compare statistics
//
// Block packing: word 0 in [127:96], word 1 in [95:64], word 2 in [63:32],
// word 3 in [31:0].
module cache_controller #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [9:0]       cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_ready,
  output logic             cpu_done,
  output logic [31:0]      cpu_rdata,
  output logic             mem_read_write,
  output logic [9:0]       mem_address,
  output logic [127:0]     mem_write_data,
  input  logic [127:0]     mem_read_data,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Latched request; only loaded in IDLE so it cannot change mid-operation.
  logic             req_we_reg;
  logic [9:2]       req_addr_reg;
  logic [31:0]      req_wdata_reg;
  // Marks the first COMPARE of a request, the only one that updates statistics.
  logic             first_cmp_reg;
  // Cycles spent so far in the current WRITEBACK/ALLOCATE memory transfer.
  logic [LAT_W-1:0] lat_cnt_reg;
  logic [CNT_W-1:0] hit_count_reg;
  logic [CNT_W-1:0] miss_count_reg;

  // Byte-offset bits carry no information for word accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^cpu_addr[1:0];

  logic [3:0] req_tag;
  logic [1:0] req_idx;
  logic [1:0] req_word;
  assign req_tag  = req_addr_reg[9:6];
  assign req_idx  = req_addr_reg[5:4];
  assign req_word = req_addr_reg[3:2];

  // Per-line state views, gathered from the line storage below.
  logic [3:0]   line_valid;
  logic [3:0]   line_dirty;
  logic [3:0]   line_tag  [4];
  logic [127:0] line_data [4];

  logic         cur_valid;
  logic         cur_dirty;
  logic [3:0]   cur_tag;
  logic [127:0] cur_data;
  logic         hit;
  logic         lat_last;
  logic         store_hit;
  logic         wb_last;
  logic         alloc_fill;
  logic [31:0]  sel_word;
  logic [127:0] store_block;

  assign cur_valid  = line_valid[req_idx];
  assign cur_dirty  = line_dirty[req_idx];
  assign cur_tag    = line_tag[req_idx];
  assign cur_data   = line_data[req_idx];
  assign hit        = cur_valid && (cur_tag == req_tag);
  assign lat_last   = (lat_cnt_reg == LAT_LAST);
  assign store_hit  = (state_reg == COMPARE) && hit && req_we_reg;
  assign wb_last    = (state_reg == WRITEBACK) && lat_last;
  assign alloc_fill = (state_reg == ALLOCATE) && lat_last;

  // Word select for loads and word merge for stores share the same packing.
  always_comb begin
    sel_word    = '0;
    store_block = cur_data;
    case (req_word)
      2'd0: begin sel_word = cur_data[127:96]; store_block[127:96] = req_wdata_reg; end
      2'd1: begin sel_word = cur_data[95:64];  store_block[95:64]  = req_wdata_reg; end
      2'd2: begin sel_word = cur_data[63:32];  store_block[63:32]  = req_wdata_reg; end
      default: begin sel_word = cur_data[31:0]; store_block[31:0] = req_wdata_reg; end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_line
      logic         valid_reg;
      logic         dirty_reg;
      logic [3:0]   tag_reg;
      logic [127:0] data_reg;
      logic         sel;

      assign sel = (req_idx == 2'(gi));

      // Status bits are the only line state that reset must clear.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_reg <= 1'b0;
          dirty_reg <= 1'b0;
        end else if (sel) begin
          if (store_hit) begin
            dirty_reg <= 1'b1;
          end else if (wb_last) begin
            dirty_reg <= 1'b0;
          end else if (alloc_fill) begin
            valid_reg <= 1'b1;
            dirty_reg <= 1'b0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (sel && store_hit) begin
          data_reg <= store_block;
        end else if (sel && alloc_fill) begin
          data_reg <= mem_read_data;
          tag_reg  <= req_tag;
        end
      end

      assign line_valid[gi] = valid_reg;
      assign line_dirty[gi] = dirty_reg;
      assign line_tag[gi]   = tag_reg;
      assign line_data[gi]  = data_reg;
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (cpu_req) state_next = COMPARE;
      end
      COMPARE: begin
        if (hit)                         state_next = IDLE;
        else if (cur_valid && cur_dirty) state_next = WRITEBACK;
        else                             state_next = ALLOCATE;
      end
      WRITEBACK: begin
        if (lat_last) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        if (lat_last) state_next = COMPARE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cpu_ready      = 1'b0;
    cpu_done       = 1'b0;
    cpu_rdata      = '0;
    mem_read_write = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    case (state_reg)
      IDLE: cpu_ready = 1'b1;
      COMPARE: begin
        cpu_done = hit;
        if (hit) cpu_rdata = sel_word;
      end
      WRITEBACK: begin
        mem_read_write = 1'b1;
        mem_address    = {cur_tag, req_idx, 4'b0000};
        mem_write_data = cur_data;
      end
      ALLOCATE: begin
        mem_address = {req_tag, req_idx, 4'b0000};
      end
      default: ;
    endcase
  end

  // Request latch, transfer timer and statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      req_we_reg     <= 1'b0;
      req_addr_reg   <= '0;
      req_wdata_reg  <= '0;
      first_cmp_reg  <= 1'b0;
      lat_cnt_reg    <= '0;
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (state_reg == IDLE && cpu_req) begin
        req_we_reg    <= cpu_we;
        req_addr_reg  <= cpu_addr[9:2];
        req_wdata_reg <= cpu_wdata;
        first_cmp_reg <= 1'b1;
      end else if (state_reg == COMPARE) begin
        first_cmp_reg <= 1'b0;
      end

      // The timer restarts on every state change, including WRITEBACK->ALLOCATE.
      if (state_reg != state_next) begin
        lat_cnt_reg <= '0;
      end else if (state_reg == WRITEBACK || state_reg == ALLOCATE) begin
        lat_cnt_reg <= lat_cnt_reg + 1'b1;
      end

      if (state_reg == COMPARE && first_cmp_reg) begin
        if (hit) begin
          if (hit_count_reg != {CNT_W{1'b1}}) hit_count_reg <= hit_count_reg + 1'b1;
        end else begin
          if (miss_count_reg != {CNT_W{1'b1}}) miss_count_reg <= miss_count_reg + 1'b1;
        end
      end
    end
  end

  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller: a block memory model, a flat word-level
// reference of memory contents, and a scoreboard of expected completions.
module tb_cache_controller;

  localparam int L  = 2;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req;
  logic          cpu_we;
  logic [9:0]    cpu_addr;
  logic [31:0]   cpu_wdata;
  logic          cpu_ready;
  logic          cpu_done;
  logic [31:0]   cpu_rdata;
  logic          mem_read_write;
  logic [9:0]    mem_address;
  logic [127:0]  mem_write_data;
  logic [127:0]  mem_read_data;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;

  always #5 clk = ~clk;

  cache_controller #(.MEM_LATENCY(L), .CNT_W(CW)) dut (
    .clk(clk),
    .reset(reset),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready),
    .cpu_done(cpu_done),
    .cpu_rdata(cpu_rdata),
    .mem_read_write(mem_read_write),
    .mem_address(mem_address),
    .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  // Main memory: 64 blocks of 128 bits, combinational read, write on clock edge.
  logic [127:0] mem [64];
  assign mem_read_data = mem[mem_address[9:4]];
  always @(posedge clk) begin
    if (mem_read_write === 1'b1) mem[mem_address[9:4]] <= mem_write_data;
  end

  // Word-level reference view of memory as the CPU should see it.
  logic [31:0] ref_mem [256];

  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] rdata;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int tests_run  = 0;
  int fail_count = 0;

  // Memory activity seen during the most recent access.
  int           wb_cyc;
  int           al_cyc;
  logic [9:0]   wb_addr;
  logic [9:0]   al_addr;
  logic [127:0] wb_data;
  bit           wb_unstable;
  bit           stray_data;

  function automatic logic [31:0] pat(input int b, input int w);
    return 32'hA000_0000 | 32'(b << 8) | 32'(w);
  endfunction

  function automatic void push_exp(input logic we, input logic [9:0] addr,
                                   input logic [31:0] wdata, input int lat);
    exp_t e;
    e.we    = we;
    e.addr  = addr;
    e.lat   = lat;
    e.rdata = we ? 32'h0 : ref_mem[addr[9:2]];
    if (we) ref_mem[addr[9:2]] = wdata;
    sb.push_back(e);
  endfunction

  task automatic clear_trace();
    wb_cyc = 0; al_cyc = 0; wb_addr = '0; al_addr = '0; wb_data = '0;
    wb_unstable = 0; stray_data = 0;
  endtask

  task automatic trace_cycle();
    if (mem_read_write === 1'b1) begin
      if (wb_cyc > 0 && (mem_address !== wb_addr || mem_write_data !== wb_data)) wb_unstable = 1;
      wb_cyc++;
      wb_addr = mem_address;
      wb_data = mem_write_data;
    end else begin
      if (mem_write_data !== 128'h0) stray_data = 1;
      if (mem_address !== 10'h0) begin
        al_cyc++;
        al_addr = mem_address;
      end
    end
  endtask

  // One access, starting and ending at a negedge; the next IDLE cycle follows.
  task automatic run_access(input logic we, input logic [9:0] addr,
                            input logic [31:0] wdata, input int lat);
    exp_t e;
    int   cyc;
    bit   seen;
    push_exp(we, addr, wdata, lat);
    clear_trace();
    tests_run++;
    if (cpu_ready !== 1'b1) begin
      fail_count++;
      $display("FAIL ready_before_%h: got %b expected 1", addr, cpu_ready);
    end
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(negedge clk);
    cpu_req = 1'b0; cpu_addr = 10'h3FC; cpu_wdata = $urandom;
    cyc = 1;
    seen = 0;
    while (cyc <= 40 && !seen) begin
      if (cpu_done === 1'b1) begin
        seen = 1;
        e = sb.pop_front();
        tests_run++;
        if (cyc !== e.lat) begin
          fail_count++;
          $display("FAIL latency_%h: got %0d expected %0d", e.addr, cyc, e.lat);
        end
        if (!e.we) begin
          tests_run++;
          if (cpu_rdata !== e.rdata) begin
            fail_count++;
            $display("FAIL rdata_%h: got %h expected %h", e.addr, cpu_rdata, e.rdata);
          end
        end
        $display("[TB] %s addr=%h lat=%0d rdata=%h", e.we ? "store" : "load ", e.addr, cyc, cpu_rdata);
      end else begin
        trace_cycle();
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      tests_run++;
      fail_count++;
      $display("FAIL timeout_%h: got no cpu_done expected one within 40 cycles", addr);
      void'(sb.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (cpu_ready !== 1'b1) begin fail_count++; $display("FAIL reset_ready: got %b expected 1", cpu_ready); end
    tests_run++;
    if (cpu_done !== 1'b0 || cpu_rdata !== 32'h0) begin
      fail_count++; $display("FAIL reset_cpu_out: got done=%b rdata=%h expected 0/0", cpu_done, cpu_rdata);
    end
    tests_run++;
    if (mem_read_write !== 1'b0 || mem_address !== 10'h0 || mem_write_data !== 128'h0) begin
      fail_count++; $display("FAIL reset_mem_out: got rw=%b addr=%h expected 0/0", mem_read_write, mem_address);
    end
    tests_run++;
    if (hit_count !== 0 || miss_count !== 0) begin
      fail_count++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", hit_count, miss_count);
    end
    $display("[TB] reset done");
  endtask

  task automatic test_clean_miss();
    run_access(1'b0, 10'h040, 32'h0, 2 + L);
    tests_run++;
    if (al_cyc !== L || al_addr !== 10'h040 || wb_cyc !== 0) begin
      fail_count++;
      $display("FAIL clean_miss_mem: got alloc=%0d@%h wb=%0d expected %0d@040 wb=0", al_cyc, al_addr, wb_cyc, L);
    end
    tests_run++;
    if (miss_count !== 1 || hit_count !== 0) begin
      fail_count++; $display("FAIL clean_miss_counts: got %0d/%0d expected hit 0 miss 1", hit_count, miss_count);
    end
  endtask

  task automatic test_hit();
    run_access(1'b0, 10'h048, 32'h0, 1);
    tests_run++;
    if (al_cyc !== 0 || wb_cyc !== 0) begin
      fail_count++; $display("FAIL hit_mem_activity: got alloc=%0d wb=%0d expected 0/0", al_cyc, wb_cyc);
    end
    tests_run++;
    if (hit_count !== 1 || miss_count !== 1) begin
      fail_count++; $display("FAIL hit_counts: got %0d/%0d expected hit 1 miss 1", hit_count, miss_count);
    end
  endtask

  task automatic test_dirty_miss();
    logic [127:0] exp_blk;
    run_access(1'b1, 10'h044, 32'hDEADBEEF, 1);
    run_access(1'b0, 10'h0C4, 32'h0, 2 + 2 * L);
    exp_blk = {pat(4, 0), 32'hDEADBEEF, pat(4, 2), pat(4, 3)};
    tests_run++;
    if (wb_cyc !== L || wb_addr !== 10'h040 || wb_unstable) begin
      fail_count++;
      $display("FAIL writeback_addr: got %0d cycles @%h unstable=%0d expected %0d @040", wb_cyc, wb_addr, wb_unstable, L);
    end
    tests_run++;
    if (wb_data !== exp_blk) begin
      fail_count++; $display("FAIL writeback_data: got %h expected %h", wb_data, exp_blk);
    end
    tests_run++;
    if (al_cyc !== L || al_addr !== 10'h0C0 || stray_data) begin
      fail_count++; $display("FAIL dirty_alloc: got %0d@%h stray=%0d expected %0d@0C0", al_cyc, al_addr, stray_data, L);
    end
    tests_run++;
    if (hit_count !== 2 || miss_count !== 2) begin
      fail_count++; $display("FAIL dirty_counts: got %0d/%0d expected hit 2 miss 2", hit_count, miss_count);
    end
  endtask

  task automatic test_refetch();
    run_access(1'b0, 10'h040, 32'h0, 2 + L);
    run_access(1'b0, 10'h044, 32'h0, 1);
  endtask

  task automatic test_reset_mid_writeback();
    run_access(1'b1, 10'h050, 32'h12345678, 2 + L);
    tests_run++;
    if (cpu_ready !== 1'b1) begin fail_count++; $display("FAIL ready_before_150: got %b expected 1", cpu_ready); end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h150;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    tests_run++;
    if (mem_read_write !== 1'b1 || mem_address !== 10'h050) begin
      fail_count++; $display("FAIL wb_start: got rw=%b addr=%h expected 1/050", mem_read_write, mem_address);
    end
    reset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (mem_read_write !== 1'b0 || cpu_ready !== 1'b1 || cpu_done !== 1'b0) begin
      fail_count++;
      $display("FAIL reset_mid_wb: got rw=%b ready=%b done=%b expected 0/1/0", mem_read_write, cpu_ready, cpu_done);
    end
    tests_run++;
    if (hit_count !== 0 || miss_count !== 0) begin
      fail_count++; $display("FAIL reset_mid_wb_counts: got %0d/%0d expected 0/0", hit_count, miss_count);
    end
    reset = 1'b0;
    $display("[TB] reset during writeback");
    // The abandoned block's memory content is unspecified; adopt whatever memory holds.
    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 4; w++) ref_mem[b * 4 + w] = mem[b][127 - 32 * w -: 32];
    run_access(1'b0, 10'h150, 32'h0, 2 + L);
    tests_run++;
    if (miss_count !== 1 || hit_count !== 0 || wb_cyc !== 0) begin
      fail_count++;
      $display("FAIL post_reset_miss: got hit=%0d miss=%0d wb=%0d expected 0/1/0", hit_count, miss_count, wb_cyc);
    end
  endtask

  task automatic test_back_to_back_hold();
    exp_t e;
    int   cyc;
    int   dones;
    int   accept_cyc;
    push_exp(1'b0, 10'h250, 32'h0, 2 + L);
    push_exp(1'b0, 10'h158, 32'h0, 2 + L);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h250;
    @(negedge clk);
    cpu_addr = 10'h158;
    cyc = 1; dones = 0; accept_cyc = 0;
    while (cyc <= 60 && dones < 2) begin
      if (cpu_done === 1'b1) begin
        dones++;
        e = sb.pop_front();
        tests_run++;
        if (cyc - accept_cyc !== e.lat) begin
          fail_count++; $display("FAIL hold_latency_%h: got %0d expected %0d", e.addr, cyc - accept_cyc, e.lat);
        end
        tests_run++;
        if (cpu_rdata !== e.rdata) begin
          fail_count++; $display("FAIL hold_rdata_%h: got %h expected %h", e.addr, cpu_rdata, e.rdata);
        end
        $display("[TB] load  addr=%h lat=%0d rdata=%h (req held)", e.addr, cyc - accept_cyc, cpu_rdata);
        accept_cyc = cyc + 1;
        if (dones == 2) cpu_req = 1'b0;
      end
      if (dones < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    if (dones < 2) begin
      cpu_req = 1'b0;
      tests_run++;
      fail_count++;
      $display("FAIL hold_timeout: got %0d cpu_done expected 2 within 60 cycles", dones);
    end
    repeat (4) begin
      @(negedge clk);
      if (cpu_done === 1'b1) dones++;
    end
    tests_run++;
    if (dones !== 2) begin
      fail_count++; $display("FAIL hold_done_count: got %0d expected 2", dones);
    end
    tests_run++;
    if (miss_count !== 3 || hit_count !== 0) begin
      fail_count++; $display("FAIL hold_counts: got %0d/%0d expected hit 0 miss 3", hit_count, miss_count);
    end
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int b = 0; b < 64; b++) begin
      mem[b] = {pat(b, 0), pat(b, 1), pat(b, 2), pat(b, 3)};
      for (int w = 0; w < 4; w++) ref_mem[b * 4 + w] = pat(b, w);
    end
    test_reset();
    test_clean_miss();
    test_hit();
    test_dirty_miss();
    test_refetch();
    test_reset_mid_writeback();
    test_back_to_back_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
